// File: rtl/spi_aes_regfile.sv
// -----------------------------------------------------------------------------
// spi_aes_regfile
//
// Register file between the SPI register-access front end and the AES-128
// core. Turns decoded SPI write/read strobes into key/input-block storage,
// AES start control and result capture, and returns read data plus the
// per-frame status byte to the front end.
//
// Ports
//   clk, rst        : clock; synchronous active-high reset
//   ena             : global enable; when low all state holds, no pulses
//   reg_addr        : register address (stable for the whole frame)
//   reg_addr_v      : read-address strobe (front end samples reg_data_i)
//   reg_rw          : 1 = write, 0 = read
//   txn_width       : write width, 00 byte / 01 halfword / 1x word
//   reg_data_o      : write data from the front end
//   reg_data_o_dv   : write strobe
//   reg_data_i      : read data to the front end (combinational)
//   status          : {run, done, err, key_valid, 4'b0}
//   aes_key         : 128-bit key, word 0 in bits [127:96]
//   aes_block       : 128-bit input block, same word order
//   aes_start       : one-cycle start pulse to the AES core
//   aes_busy        : AES core busy
//   aes_done        : one-cycle completion pulse from the AES core
//   aes_result      : AES result, valid with aes_done
//
// Address map: 0-3 KEY, 4-7 DIN, 8 CTRL (wo), 9 STATUS, 12-15 DOUT (ro).
// The 128-bit AES buses are built from four 32-bit words, so REG_W is 32.
// -----------------------------------------------------------------------------
module spi_aes_regfile #(
   parameter int ADDR_W = 4,
   parameter int REG_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic              reg_addr_v,
   input  logic              reg_rw,
   input  logic [1:0]        txn_width,
   input  logic [REG_W-1:0]  reg_data_o,
   input  logic              reg_data_o_dv,
   output logic [REG_W-1:0]  reg_data_i,
   output logic [7:0]        status,
   output logic [127:0]      aes_key,
   output logic [127:0]      aes_block,
   output logic              aes_start,
   input  logic              aes_busy,
   input  logic              aes_done,
   input  logic [127:0]      aes_result
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t           state_q, state_d;
   logic [REG_W-1:0] key_q  [4];
   logic [REG_W-1:0] din_q  [4];
   logic [REG_W-1:0] dout_q [4];
   logic             done_q, err_q;
   logic [3:0]       key_full_q;   // word-width write seen per key word

   // Address decode: upper bits select a group of four words.
   logic [ADDR_W-3:0] grp;
   logic [1:0]        idx;
   logic key_hit, din_hit, dout_hit, ctrl_hit, stat_hit;

   assign grp      = reg_addr[ADDR_W-1:2];
   assign idx      = reg_addr[1:0];
   assign key_hit  = (grp == '0);
   assign din_hit  = (grp == (ADDR_W-2)'(1));
   assign dout_hit = (grp == (ADDR_W-2)'(3));
   assign ctrl_hit = (reg_addr == ADDR_W'(8));
   assign stat_hit = (reg_addr == ADDR_W'(9));

   // Strobe qualification. Every event is gated by ena here, so the
   // sequential block below needs no separate enable.
   logic wr_en, locked, start_req, clr_req, start_fire;
   logic data_wr, err_set, stat_rd, done_set;

   assign wr_en      = ena & reg_data_o_dv & reg_rw;
   // A run in progress, or a core still busy, locks KEY/DIN/START.
   assign locked     = (state_q == ST_RUN) | aes_busy;
   assign start_req  = wr_en & ctrl_hit & reg_data_o[0];
   assign clr_req    = wr_en & ctrl_hit & reg_data_o[1];
   assign start_fire = start_req & ~locked;
   assign data_wr    = wr_en & (key_hit | din_hit);
   assign err_set    = (data_wr | start_req) & locked;
   assign stat_rd    = ena & reg_addr_v & ~reg_rw & stat_hit;
   assign done_set   = ena & aes_done;

   // Partial-width write: only the low byte/halfword of the target changes.
   function automatic logic [REG_W-1:0] merge(input logic [REG_W-1:0] old_v,
                                              input logic [REG_W-1:0] new_v,
                                              input logic [1:0]       width);
      logic [REG_W-1:0] r;
      r = old_v;
      case (width)
         2'b00:   r[7:0]  = new_v[7:0];
         2'b01:   r[15:0] = new_v[15:0];
         default: r       = new_v;
      endcase
      return r;
   endfunction

   // Start FSM next state.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_fire)          state_d = ST_RUN;
         ST_RUN:  if (ena && aes_done)     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the word arrays are reset explicitly; they are a handful of
         // flops, not a RAM, and must read back 0 after reset.
         for (int i = 0; i < 4; i++) begin
            key_q[i]  <= '0;
            din_q[i]  <= '0;
            dout_q[i] <= '0;
         end
         state_q    <= ST_IDLE;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         key_full_q <= '0;
         aes_start  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout so every register sees
         // the pre-edge values of the others, independent of statement order.
         state_q   <= state_d;
         aes_start <= start_fire;
         if (data_wr && !locked) begin
            if (key_hit) begin
               key_q[idx]      <= merge(key_q[idx], reg_data_o, txn_width);
               key_full_q[idx] <= key_full_q[idx] | txn_width[1];
            end else begin
               din_q[idx]      <= merge(din_q[idx], reg_data_o, txn_width);
            end
         end
         // aes_done is honoured in either state so no result is lost.
         if (done_set) begin
            for (int i = 0; i < 4; i++)
               dout_q[i] <= REG_W'(aes_result[127-32*i -: 32]);
         end
         // Setting wins over clearing on the same cycle.
         done_q <= done_set | (done_q & ~(clr_req | stat_rd));
         err_q  <= err_set  | (err_q  & ~clr_req);
      end
   end

   assign status = {state_q == ST_RUN, done_q, err_q, &key_full_q, 4'b0000};

   always_comb begin
      aes_key   = '0;
      aes_block = '0;
      for (int i = 0; i < 4; i++) begin
         aes_key[127-32*i -: 32]   = key_q[i][31:0];
         aes_block[127-32*i -: 32] = din_q[i][31:0];
      end
   end

   always_comb begin
      reg_data_i = '0;
      if (key_hit)       reg_data_i = key_q[idx];
      else if (din_hit)  reg_data_i = din_q[idx];
      else if (dout_hit) reg_data_i = dout_q[idx];
      else if (stat_hit) reg_data_i = REG_W'(status);
   end

endmodule

// File: tb/tb_spi_aes_regfile.sv
// -----------------------------------------------------------------------------
// Self-checking bench for spi_aes_regfile. A transaction-level model (word
// arrays plus sticky flags, updated once per clock from the applied strobes)
// predicts every output; directed steps cover the key test vectors, partial
// writes, start/result flow, lockout errors, clear priorities and reset
// mid-run, with a randomized register-traffic section in between.
// -----------------------------------------------------------------------------
module tb_spi_aes_regfile;

   logic         clk = 1'b0;
   logic         rst, ena;
   logic [3:0]   reg_addr;
   logic         reg_addr_v, reg_rw, reg_data_o_dv;
   logic [1:0]   txn_width;
   logic [31:0]  reg_data_o, reg_data_i;
   logic [7:0]   status;
   logic [127:0] aes_key, aes_block, aes_result;
   logic         aes_start, aes_busy, aes_done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   spi_aes_regfile #(.ADDR_W(4), .REG_W(32)) dut (
      .clk(clk), .rst(rst), .ena(ena),
      .reg_addr(reg_addr), .reg_addr_v(reg_addr_v), .reg_rw(reg_rw),
      .txn_width(txn_width), .reg_data_o(reg_data_o),
      .reg_data_o_dv(reg_data_o_dv), .reg_data_i(reg_data_i),
      .status(status), .aes_key(aes_key), .aes_block(aes_block),
      .aes_start(aes_start), .aes_busy(aes_busy), .aes_done(aes_done),
      .aes_result(aes_result)
   );

   // ---------------- reference model ----------------
   logic [31:0] key_m [4];
   logic [31:0] din_m [4];
   logic [31:0] dout_m[4];
   logic        done_m, err_m, run_m, exp_start;
   logic [3:0]  wrote_m;

   function automatic logic [7:0] mstatus();
      return {run_m, done_m, err_m, (wrote_m == 4'hF), 4'b0000};
   endfunction

   function automatic logic [31:0] mread(input int a);
      if (a < 4)       return key_m[a];
      else if (a < 8)  return din_m[a-4];
      else if (a == 9) return {24'd0, mstatus()};
      else if (a >= 12) return dout_m[a-12];
      return 32'd0;
   endfunction

   function automatic logic [127:0] words(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
      return {w0, w1, w2, w3};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         key_m[i] = 0; din_m[i] = 0; dout_m[i] = 0;
      end
      done_m = 0; err_m = 0; run_m = 0; wrote_m = 0; exp_start = 0;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: update the model from the inputs currently applied, advance
   // the DUT, drop the one-cycle strobes, then compare all registered outputs.
   task automatic step();
      logic [31:0] m;
      logic        busy, wr, rd9;
      int          a;
      exp_start = 0;
      if (ena) begin
         a    = int'(reg_addr);
         busy = run_m || aes_busy;
         wr   = reg_data_o_dv && reg_rw;
         rd9  = reg_addr_v && !reg_rw && (a == 9);
         m    = txn_width[1] ? 32'hFFFF_FFFF : (txn_width[0] ? 32'h0000_FFFF : 32'h0000_00FF);
         // clears first
         if (rd9) done_m = 0;
         if (wr && a == 8 && reg_data_o[1]) begin done_m = 0; err_m = 0; end
         // then sets
         if (wr && a < 8) begin
            if (busy) err_m = 1;
            else if (a < 4) begin
               key_m[a] = (key_m[a] & ~m) | (reg_data_o & m);
               if (txn_width[1]) wrote_m[a] = 1;
            end else
               din_m[a-4] = (din_m[a-4] & ~m) | (reg_data_o & m);
         end
         if (aes_done) begin
            dout_m[0] = aes_result[127:96]; dout_m[1] = aes_result[95:64];
            dout_m[2] = aes_result[63:32];  dout_m[3] = aes_result[31:0];
            done_m = 1; run_m = 0;
         end
         if (wr && a == 8 && reg_data_o[0]) begin
            if (busy) err_m = 1;
            else begin exp_start = 1; run_m = 1; end
         end
      end
      @(posedge clk); #1;
      reg_data_o_dv = 0; reg_addr_v = 0; aes_done = 0;
      check("aes_start", 128'(aes_start), 128'(exp_start));
      check("aes_key",   aes_key,   words(key_m[0], key_m[1], key_m[2], key_m[3]));
      check("aes_block", aes_block, words(din_m[0], din_m[1], din_m[2], din_m[3]));
      check("status",    128'(status), 128'(mstatus()));
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [1:0] w);
      reg_addr = a; reg_rw = 1; txn_width = w; reg_data_o = d; reg_data_o_dv = 1;
      step();
   endtask

   task automatic rd(input logic [3:0] a);
      reg_addr = a; reg_rw = 0; reg_addr_v = 1;
      #1;
      check($sformatf("read_%0d", a), 128'(reg_data_i), 128'(mread(int'(a))));
      step();
   endtask

   task automatic peek(input string tag, input logic [3:0] a, input logic [31:0] exp);
      reg_addr = a; reg_rw = 0;
      #1;
      check(tag, 128'(reg_data_i), 128'(exp));
   endtask

   task automatic do_reset();
      rst = 1;
      @(posedge clk); #1;
      rst = 0; reg_data_o_dv = 0; reg_addr_v = 0; aes_done = 0;
      model_reset();
      check("rst_key",   aes_key,   128'd0);
      check("rst_block", aes_block, 128'd0);
      check("rst_start", 128'(aes_start), 128'd0);
      check("rst_status", 128'(status), 128'd0);
      peek("rst_read0", 4'd0, 32'd0);
   endtask

   initial begin
      logic [3:0]  a;
      logic [31:0] d;
      rst = 1; ena = 1; reg_addr = 0; reg_addr_v = 0; reg_rw = 0;
      txn_width = 2'b10; reg_data_o = 0; reg_data_o_dv = 0;
      aes_busy = 0; aes_done = 0; aes_result = 0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Key test vector at word width -> key_valid.
      wr(4'd0, 32'h2b7e1516, 2'b10);
      wr(4'd1, 32'h28aed2a6, 2'b10);
      wr(4'd2, 32'habf71588, 2'b10);
      wr(4'd3, 32'h09cf4f3c, 2'b11);
      check("key_vector", aes_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      check("key_valid", 128'(status[4]), 128'd1);

      // Partial-width writes.
      wr(4'd4, 32'h11223344, 2'b10);
      wr(4'd4, 32'hFFFF_FFAA, 2'b00);
      peek("din_byte", 4'd4, 32'h112233AA);
      wr(4'd4, 32'h5555_BEEF, 2'b01);
      peek("din_half", 4'd4, 32'h1122BEEF);

      // Randomized register traffic (no CTRL writes), occasional idle done.
      for (int n = 0; n < 80; n++) begin
         a = 4'($urandom_range(0, 15));
         if (a == 4'd8) a = 4'd10;
         ena = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 7) == 0) begin
            aes_done = 1;
            aes_result = {$urandom, $urandom, $urandom, $urandom};
         end
         if ($urandom_range(0, 1) == 1) wr(a, $urandom, 2'($urandom_range(0, 3)));
         else rd(a);
      end
      ena = 1;

      // Clean slate, then a normal run.
      wr(4'd8, 32'h2, 2'b10);
      wr(4'd8, 32'h1, 2'b10);
      check("run_bit", 128'(status[7]), 128'd1);
      step();
      aes_result = 128'h3925841d02dc09fbdc118597196a0b32;
      aes_done = 1;
      step();
      peek("dout0", 4'd12, 32'h3925841d);
      peek("dout3", 4'd15, 32'h196a0b32);
      check("status_done", 128'(status), 128'h50);

      // Status read returns the byte, then clears done.
      rd(4'd9);
      check("done_cleared", 128'(status[6]), 128'd0);

      // Lockout while the core reports busy.
      aes_busy = 1;
      wr(4'd8, 32'h1, 2'b10);
      wr(4'd0, 32'hdeadbeef, 2'b10);
      check("err_set", 128'(status[5]), 128'd1);
      wr(4'd8, 32'h2, 2'b10);
      check("err_clr", 128'(status[5]), 128'd0);
      aes_busy = 0;

      // Lockout in RUN, then aes_done coincident with CLR.
      wr(4'd8, 32'h1, 2'b10);
      wr(4'd1, 32'h01234567, 2'b10);
      aes_done = 1; aes_result = {$urandom, $urandom, $urandom, $urandom};
      wr(4'd8, 32'h2, 2'b10);
      check("done_wins_clr", 128'(status[6]), 128'd1);
      // aes_done coincident with a status read.
      aes_done = 1;
      rd(4'd9);
      check("done_wins_rd", 128'(status[6]), 128'd1);

      // START+CLR together: clear then start; reset while running.
      wr(4'd8, 32'h3, 2'b10);
      do_reset();
      peek("rst_dout", 4'd12, 32'd0);
      aes_done = 1; aes_result = 128'h00112233445566778899aabbccddeeff;
      step();
      rd(4'd12);
      rd(4'd9);

      // ena low drops strobes.
      ena = 0;
      wr(4'd0, 32'hcafef00d, 2'b10);
      wr(4'd8, 32'h1, 2'b10);
      ena = 1;
      rd(4'd0);
      rd(4'd8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
